// File: rtl/fpv_pixel_sink.sv
// fpv_pixel_sink: buffers renderer pixel writes in a FIFO and drains them into
// the 160x120 framebuffer port on granted cycles. Also reports when a finished
// frame has been fully committed to memory.
module fpv_pixel_sink #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [17:0] vga_colour,
  input  logic        vga_write,
  input  logic        frame_done,
  input  logic        fb_grant,
  output logic [14:0] fb_addr,
  output logic [17:0] fb_data,
  output logic        fb_we,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  oob_count,
  input  logic        clear_flags,
  output logic        frame_committed
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int ENT_W = 15 + 18;

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_COMMIT} state_t;

  // Saturating increment for the out-of-range drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_fb_we;
  logic [14:0]      r_fb_addr;
  logic [17:0]      r_fb_data;
  logic             r_overflow;
  logic [7:0]       r_oob_count;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_committed;

  logic             w_in_range;
  logic [14:0]      w_addr;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_oob;

  assign w_in_range = (int'(vga_x) < SCREEN_W) && (int'(vga_y) < SCREEN_H);
  assign w_addr     = 15'(vga_y) * 15'(SCREEN_W) + 15'(vga_x);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  // A pop frees a slot at the same edge, so a full FIFO can still accept.
  assign w_pop      = fb_grant & ~w_empty;
  assign w_push     = vga_write & w_in_range & (~w_full | w_pop);
  assign w_drop     = vga_write & w_in_range & w_full & ~w_pop;
  assign w_oob      = vga_write & ~w_in_range;

  // ---- stage 0: FIFO storage (data only, no reset needed)
  // Store the precomputed word address alongside the colour on push.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_addr, vga_colour};
  end

  // Pointer and occupancy bookkeeping; reset discards buffered pixels.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- stage 1: framebuffer port register
  // Register the head entry for exactly one cycle per pop; address/data hold otherwise.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else begin
      r_fb_we <= w_pop;
      if (w_pop) {r_fb_addr, r_fb_data} <= r_mem[r_rd_ptr];
    end
  end

  // Sticky drop flags; a drop on the same edge as clear_flags takes priority.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_oob_count <= '0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (clear_flags) r_overflow <= 1'b0;
      if (w_oob)            r_oob_count <= clear_flags ? 8'd1 : sat_inc8(r_oob_count);
      else if (clear_flags) r_oob_count <= '0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Frame FSM next state and commit pulse. With the FIFO empty and nothing
  // arriving, any write on the port this cycle lands at this edge, so the
  // commit pulse follows directly after the final write cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_committed = 1'b0;
    case (r_state)
      ST_RUN:    if (frame_done) w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (w_empty && !w_push) w_state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        w_committed = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  assign fb_we           = r_fb_we;
  assign fb_addr         = r_fb_addr;
  assign fb_data         = r_fb_data;
  assign fifo_empty      = w_empty;
  assign fifo_full       = w_full;
  assign overflow        = r_overflow;
  assign oob_count       = r_oob_count;
  assign frame_committed = w_committed;

endmodule

// File: tb/tb_fpv_pixel_sink.sv
// tb_fpv_pixel_sink: directed checks of the pixel sink FIFO, range filter,
// drop flags and frame-commit pulse.
module tb_fpv_pixel_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  vga_x = '0;
  logic [6:0]  vga_y = '0;
  logic [17:0] vga_colour = '0;
  logic        vga_write = 1'b0;
  logic        frame_done = 1'b0;
  logic        fb_grant = 1'b0;
  logic        clear_flags = 1'b0;
  logic [14:0] fb_addr;
  logic [17:0] fb_data;
  logic        fb_we;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [7:0]  oob_count;
  logic        frame_committed;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int          wcyc_q[$];
  logic [14:0] waddr_q[$];
  logic [17:0] wdata_q[$];
  int          ccyc_q[$];

  fpv_pixel_sink #(.DEPTH(16), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write),
    .frame_done(frame_done), .fb_grant(fb_grant),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .overflow(overflow), .oob_count(oob_count), .clear_flags(clear_flags),
    .frame_committed(frame_committed)
  );

  always #5 clock = ~clock;

  // Cycle counter advances at each active edge.
  always @(posedge clock) cyc <= cyc + 1;

  // Log framebuffer writes and commit pulses mid-cycle.
  always @(negedge clock) begin
    if (fb_we) begin
      wcyc_q.push_back(cyc);
      waddr_q.push_back(fb_addr);
      wdata_q.push_back(fb_data);
    end
    if (frame_committed) ccyc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic px(input int x, input int y, input int c);
    vga_x      = 8'(x);
    vga_y      = 7'(y);
    vga_colour = 18'(c);
    vga_write  = 1'b1;
    tick();
    vga_write  = 1'b0;
  endtask

  task automatic clear_log();
    wcyc_q.delete();
    waddr_q.delete();
    wdata_q.delete();
    ccyc_q.delete();
  endtask

  initial begin
    int c0;
    int last;

    // Reset state
    reset = 1'b0;
    ticks(2);
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_data), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_oob", 32'(oob_count), 0);
    check("rst_commit", 32'(frame_committed), 0);
    reset = 1'b1;
    tick();
    clear_log();

    // Single pixel: fb_we two cycles after the write cycle
    fb_grant = 1'b1;
    c0 = cyc;
    px(5, 2, 18'h3FFFF);
    ticks(5);
    check("single_nwr", 32'(wcyc_q.size()), 1);
    if (wcyc_q.size() == 1) begin
      check("single_cyc", 32'(wcyc_q[0]), 32'(c0 + 2));
      check("single_addr", 32'(waddr_q[0]), 325);
      check("single_data", 32'(wdata_q[0]), 32'h3FFFF);
    end

    // Grant stall: fill to 16, then drain in order back-to-back
    clear_log();
    fb_grant = 1'b0;
    for (int i = 0; i < 16; i++) px(i, 0, 100 + i);
    check("stall_full", 32'(fifo_full), 1);
    check("stall_nowr", 32'(wcyc_q.size()), 0);
    fb_grant = 1'b1;
    ticks(20);
    check("stall_nwr", 32'(wcyc_q.size()), 16);
    if (wcyc_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("stall_addr%0d", i), 32'(waddr_q[i]), 32'(i));
        check($sformatf("stall_data%0d", i), 32'(wdata_q[i]), 32'(100 + i));
        check($sformatf("stall_cyc%0d", i), 32'(wcyc_q[i]), 32'(wcyc_q[0] + i));
      end
    end
    check("stall_empty", 32'(fifo_empty), 1);
    check("stall_ovf", 32'(overflow), 0);

    // Overflow: 17th pixel dropped, flag sticky until cleared
    clear_log();
    fb_grant = 1'b0;
    for (int i = 0; i < 17; i++) px(i, 1, i);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_full", 32'(fifo_full), 1);
    fb_grant = 1'b1;
    ticks(20);
    check("ovf_nwr", 32'(wcyc_q.size()), 16);
    if (wcyc_q.size() == 16) check("ovf_last_addr", 32'(waddr_q[15]), 175);
    check("ovf_still", 32'(overflow), 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovf_clear", 32'(overflow), 0);

    // Range check and saturation
    clear_log();
    px(160, 0, 1);
    px(0, 120, 2);
    px(159, 119, 3);
    ticks(5);
    check("oob_two", 32'(oob_count), 2);
    check("oob_nwr", 32'(wcyc_q.size()), 1);
    if (wcyc_q.size() == 1) begin
      check("oob_addr", 32'(waddr_q[0]), 19199);
      check("oob_data", 32'(wdata_q[0]), 3);
    end
    for (int i = 0; i < 300; i++) px(200, 0, 0);
    check("oob_sat", 32'(oob_count), 255);
    clear_flags = 1'b1;
    px(0, 127, 0);
    clear_flags = 1'b0;
    check("oob_clr_evt", 32'(oob_count), 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("oob_clr", 32'(oob_count), 0);

    // Frame commit: 120-pixel column, grant toggling, pixel every other cycle
    ticks(4);
    clear_log();
    for (int y = 0; y < 120; y++) begin
      fb_grant = cyc[0];
      px(79, y, y);
      fb_grant = cyc[0];
      tick();
    end
    fb_grant = cyc[0];
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      fb_grant = cyc[0];
      tick();
    end
    fb_grant = 1'b1;
    check("frm_nwr", 32'(wcyc_q.size()), 120);
    if (wcyc_q.size() == 120) begin
      for (int y = 0; y < 120; y += 17)
        check($sformatf("frm_addr%0d", y), 32'(waddr_q[y]), 32'(y * 160 + 79));
      check("frm_addr_last", 32'(waddr_q[119]), 32'(119 * 160 + 79));
    end
    check("frm_ncommit", 32'(ccyc_q.size()), 1);
    if (ccyc_q.size() == 1 && wcyc_q.size() > 0) begin
      last = wcyc_q[wcyc_q.size() - 1];
      check("frm_commit_cyc", 32'(ccyc_q[0]), 32'(last + 1));
    end
    check("frm_ovf", 32'(overflow), 0);

    // frame_done with nothing pending: pulse two cycles later
    clear_log();
    c0 = cyc;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    ticks(5);
    check("empty_ncommit", 32'(ccyc_q.size()), 1);
    if (ccyc_q.size() == 1) check("empty_commit_cyc", 32'(ccyc_q[0]), 32'(c0 + 2));

    // Reset mid-operation discards buffered pixels and clears flags
    fb_grant = 1'b0;
    px(200, 0, 0);
    for (int i = 0; i < 8; i++) px(i, 3, i);
    check("mid_notempty", 32'(fifo_empty), 0);
    check("mid_oob_pre", 32'(oob_count), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_we", 32'(fb_we), 0);
    check("mid_empty", 32'(fifo_empty), 1);
    check("mid_oob", 32'(oob_count), 0);
    check("mid_ovf", 32'(overflow), 0);
    clear_log();
    fb_grant = 1'b1;
    ticks(10);
    check("mid_nostale", 32'(wcyc_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
